bus_host_arbiter: RTL and testbench
===================================

Name: bus_host_arbiter

Overview:
- Round-robin arbiter that shares one device-side bus port between up to 4 bus hosts: core data port, debug-module SBA master, and a future DMA.
- Sits between the hosts and the address-decoding bus fabric; the fabric sees a single host.
- Tracks outstanding transactions in an in-order ID FIFO so each response returns to the host that issued the request.
- Supports pipelined requests, up to MaxOutstanding in flight.

Parameters:
- NrHosts, 2: number of requesting hosts; legal range 2..4.
- DataWidth, 32: data bus width in bits.
- AddressWidth, 32: address bus width in bits.
- MaxOutstanding, 2: depth of the response-routing FIFO; legal range 1..4.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- host_req_i  in  [NrHosts] x 1  per-host request
- host_gnt_o  out  [NrHosts] x 1  per-host grant
- host_addr_i  in  [NrHosts] x AddressWidth  per-host address
- host_we_i  in  [NrHosts] x 1  per-host write enable
- host_be_i  in  [NrHosts] x DataWidth/8  per-host byte enables
- host_wdata_i  in  [NrHosts] x DataWidth  per-host write data
- host_rvalid_o  out  [NrHosts] x 1  per-host response valid
- host_rdata_o  out  [NrHosts] x DataWidth  response data, broadcast to all hosts
- host_err_o  out  [NrHosts] x 1  per-host response error, qualified by host_rvalid_o
- dev_req_o  out  1  downstream request
- dev_gnt_i  in  1  downstream accept; tie to 1 for the current always-accept fabric
- dev_addr_o  out  AddressWidth  downstream address
- dev_we_o  out  1  downstream write enable
- dev_be_o  out  DataWidth/8  downstream byte enables
- dev_wdata_o  out  DataWidth  downstream write data
- dev_rvalid_i  in  1  downstream response valid
- dev_rdata_i  in  DataWidth  downstream response data
- dev_err_i  in  1  downstream response error
- spurious_rsp_o  out  1  sticky flag: a response arrived with no transaction outstanding

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - rr_ptr = 0, FIFO empty (count 0), spurious_rsp_o = 0.
  - All host_gnt_o, host_rvalid_o, host_err_o and dev_req_o are 0 while in reset.
- Arbitration (combinational, same cycle as request):
  - can_issue = (count < MaxOutstanding).
  - Winner: the first host with host_req_i = 1, searching from index rr_ptr upward and wrapping modulo NrHosts.
  - dev_req_o = can_issue & |host_req_i.
  - dev_addr/we/be/wdata are muxed from the winner; they are don't-care when dev_req_o = 0.
  - host_gnt_o[winner] = dev_req_o & dev_gnt_i; all other grants are 0.
  - When can_issue = 0, no grant is given and dev_req_o = 0. Hosts hold their request (OBI-style).
- Pointer update:
  - On a handshake (dev_req_o & dev_gnt_i), rr_ptr <= (winner + 1) mod NrHosts.
  - Otherwise rr_ptr holds.
  - Fairness bound: a continuously requesting host is granted within NrHosts handshakes.
- Response routing:
  - Each handshake pushes the winner's index into the ID FIFO.
  - A dev_rvalid_i with count > 0 pops the head entry h. In the same cycle: host_rvalid_o[h] = 1 and host_err_o[h] = dev_err_i; all other host_rvalid_o and host_err_o are 0.
  - host_rdata_o = dev_rdata_i for every host, unregistered.
  - Response is combinational pass-through: zero added latency in either direction.
- Simultaneous push and pop: count is unchanged; the FIFO head/tail pointers both advance and wrap modulo MaxOutstanding.
- Full FIFO with a pop in the same cycle: no issue that cycle. can_issue uses the registered count only, so there is no combinational path from dev_rvalid_i to dev_req_o.
- Spurious response: dev_rvalid_i with count = 0 is dropped (no host_rvalid_o) and sets spurious_rsp_o, which stays 1 until reset.
- Reset mid-operation: all state clears asynchronously; in-flight responses are discarded.
- Assertions:
  - Grants are one-hot or zero.
  - count never exceeds MaxOutstanding.
  - The request signals of a non-granted requesting host must stay stable until it is granted.
- Implementation notes:
  - The only state is rr_ptr, the FIFO, count and the sticky flag.
  - No additional pipeline registers.

Test Plan:
- Single host: host0 reads 0x00100000 with dev_gnt_i = 1, rvalid the next cycle with rdata 0xDEADBEEF -> host_gnt_o[0] = 1 in cycle 0; host_rvalid_o[0] = 1 with rdata 0xDEADBEEF in cycle 1; host_rvalid_o[1] = 0.
- Round-robin: NrHosts = 3, all hosts request continuously, dev_gnt_i = 1 -> grant order 0, 1, 2, 0, 1, 2; host1 is never starved.
- Backpressure: MaxOutstanding = 2, device withholds rvalid for 5 cycles -> exactly 2 grants, then dev_req_o = 0 until the first rvalid; the next grant comes one cycle after the pop.
- Out-of-order-free routing: host1 then host0 issue back-to-back, responses 0x11 then 0x22 with dev_err_i = 1 on the second -> host1 gets 0x11 with err 0; host0 gets 0x22 with err 1.
- dev_gnt_i = 0 for 3 cycles while host0 requests -> no grant, rr_ptr unchanged, request fields stable on dev_*; the grant occurs in the cycle dev_gnt_i rises.
- Spurious response: rvalid with an empty FIFO -> no host_rvalid_o and spurious_rsp_o = 1. Then assert rst_ni low mid-transaction -> count = 0, the flag clears, and a subsequent rvalid sets the flag again.

Source files
------------

// File: rtl/bus_host_arbiter_if.sv
// Bus bundle between the hosts, the arbiter and the downstream fabric port.
// The arbiter connects through the slave modport. The bench, which plays both
// the hosts and the fabric, connects through the master modport.
interface bus_host_arbiter_if #(
  parameter int NrHosts      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  // host side
  logic [NrHosts-1:0]                    host_req_i;
  logic [NrHosts-1:0]                    host_gnt_o;
  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i;
  logic [NrHosts-1:0]                    host_we_i;
  logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i;
  logic [NrHosts-1:0]                    host_rvalid_o;
  logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o;
  logic [NrHosts-1:0]                    host_err_o;
  // device side
  logic                                  dev_req_o;
  logic                                  dev_gnt_i;
  logic [AddressWidth-1:0]               dev_addr_o;
  logic                                  dev_we_o;
  logic [DataWidth/8-1:0]                dev_be_o;
  logic [DataWidth-1:0]                  dev_wdata_o;
  logic                                  dev_rvalid_i;
  logic [DataWidth-1:0]                  dev_rdata_i;
  logic                                  dev_err_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
  );
endinterface

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one downstream bus port among NrHosts hosts.
// The request and response paths are purely combinational. An in-order FIFO
// of winner indices steers each response back to the host that issued it.
// Issue is gated on the registered outstanding count only, so there is no
// combinational path from dev_rvalid_i to dev_req_o.
module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  bus_host_arbiter_if.slave   bus,
  output logic                spurious_rsp_o
);
  localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NrHosts - 1);

  logic [IdxW-1:0]         r_rr_ptr;
  logic [IdxW-1:0]         r_fifo [MaxOutstanding];
  logic [PtrW-1:0]         r_wr_ptr;
  logic [PtrW-1:0]         r_rd_ptr;
  logic [CntW-1:0]         r_count;
  logic                    r_spurious;

  logic [IdxW-1:0]         w_winner;
  logic [IdxW-1:0]         w_idx;
  logic [IdxW-1:0]         w_head;
  logic                    w_can_issue;
  logic                    w_dev_req;
  logic                    w_push;
  logic                    w_pop;
  logic [AddressWidth-1:0] w_addr;
  logic [DataWidth-1:0]    w_wdata;
  logic [DataWidth/8-1:0]  w_be;
  logic                    w_we;

  // Winner search: the lowest offset from r_rr_ptr with a request wins. The
  // loop runs from the largest offset down so the last hit is the closest one.
  always_comb begin
    w_winner = r_rr_ptr;
    w_idx    = '0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      w_idx = IdxW'((int'(r_rr_ptr) + i) % NrHosts);
      if (bus.host_req_i[w_idx]) w_winner = w_idx;
    end
  end

  // Issue side: request qualification, field mux and the single grant.
  always_comb begin
    w_can_issue = (r_count < MaxCnt);
    w_dev_req   = rst_ni & w_can_issue & (|bus.host_req_i);
    w_push      = w_dev_req & bus.dev_gnt_i;
    w_addr      = bus.host_addr_i[w_winner];
    w_we        = bus.host_we_i[w_winner];
    w_be        = bus.host_be_i[w_winner];
    w_wdata     = bus.host_wdata_i[w_winner];
    bus.dev_req_o   = w_dev_req;
    bus.dev_addr_o  = w_addr;
    bus.dev_we_o    = w_we;
    bus.dev_be_o    = w_be;
    bus.dev_wdata_o = w_wdata;
    bus.host_gnt_o  = '0;
    for (int h = 0; h < NrHosts; h++) begin
      bus.host_gnt_o[h] = w_push && (w_winner == IdxW'(h));
    end
  end

  // Response side: route the response to the FIFO head and broadcast rdata.
  always_comb begin
    w_head            = r_fifo[r_rd_ptr];
    w_pop             = bus.dev_rvalid_i && (r_count != '0);
    bus.host_rvalid_o = '0;
    bus.host_err_o    = '0;
    bus.host_rdata_o  = '0;
    for (int h = 0; h < NrHosts; h++) begin
      bus.host_rvalid_o[h] = w_pop && (w_head == IdxW'(h));
      bus.host_err_o[h]    = w_pop && (w_head == IdxW'(h)) && bus.dev_err_i;
      bus.host_rdata_o[h]  = bus.dev_rdata_i;
    end
  end

  // Round-robin pointer moves past the winner on every handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_winner == IdxLast) ? '0 : w_winner + IdxW'(1);
    end
  end

  // Response-routing FIFO: push winner on handshake, pop on a valid response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_winner;
        r_wr_ptr         <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_spurious <= 1'b0;
    end else if (bus.dev_rvalid_i && (r_count == '0)) begin
      r_spurious <= 1'b1;
    end
  end

  assign spurious_rsp_o = r_spurious;

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.host_gnt_o));

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= MaxCnt);

  // A host that is requesting but not granted must hold its request fields.
  for (genvar h = 0; h < NrHosts; h++) begin : g_req_stable
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.host_req_i[h] && !bus.host_gnt_o[h]) |=>
        (bus.host_req_i[h] && $stable(bus.host_addr_i[h]) &&
         $stable(bus.host_we_i[h]) && $stable(bus.host_be_i[h]) &&
         $stable(bus.host_wdata_i[h])));
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter with three hosts and two outstanding.
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge.
module tb_bus_host_arbiter;
  localparam int NH = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 2;

  logic clk;
  logic rst_n;
  logic spurious;
  int   n_tests;
  int   n_fail;
  int   order [6];
  logic [AW-1:0] rr_addr [3];

  bus_host_arbiter_if #(.NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) bus ();

  bus_host_arbiter #(
    .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus.slave),
    .spurious_rsp_o (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    order   = '{0, 1, 2, 0, 1, 2};
    rr_addr = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    rst_n   = 1'b0;
    bus.host_req_i   = '0;
    bus.host_addr_i  = '0;
    bus.host_we_i    = '0;
    bus.host_be_i    = '0;
    bus.host_wdata_i = '0;
    bus.dev_gnt_i    = 1'b1;
    bus.dev_rvalid_i = 1'b0;
    bus.dev_rdata_i  = '0;
    bus.dev_err_i    = 1'b0;

    // reset: outputs quiet even with requests and a response present
    bus.host_req_i   = 3'b111;
    bus.dev_rvalid_i = 1'b1;
    bus.dev_err_i    = 1'b1;
    @(negedge clk);
    check_eq("rst_gnt", bus.host_gnt_o, 3'b000);
    check_eq("rst_dev_req", bus.dev_req_o, 1'b0);
    check_eq("rst_rvalid", bus.host_rvalid_o, 3'b000);
    check_eq("rst_err", bus.host_err_o, 3'b000);
    check_eq("rst_spurious", spurious, 1'b0);
    bus.host_req_i   = '0;
    bus.dev_rvalid_i = 1'b0;
    bus.dev_err_i    = 1'b0;
    step();
    rst_n = 1'b1;

    // single host read
    bus.host_addr_i[0] = 32'h0010_0000;
    bus.host_be_i[0]   = 4'hF;
    bus.host_req_i[0]  = 1'b1;
    @(negedge clk);
    check_eq("single_gnt", bus.host_gnt_o, 3'b001);
    check_eq("single_dev_req", bus.dev_req_o, 1'b1);
    check_eq("single_dev_addr", bus.dev_addr_o, 32'h0010_0000);
    check_eq("single_dev_we", bus.dev_we_o, 1'b0);
    step();
    bus.host_req_i[0] = 1'b0;
    bus.dev_rvalid_i  = 1'b1;
    bus.dev_rdata_i   = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("single_rvalid", bus.host_rvalid_o, 3'b001);
    check_eq("single_rvalid1", bus.host_rvalid_o[1], 1'b0);
    check_eq("single_rdata", bus.host_rdata_o[0], 32'hDEAD_BEEF);
    check_eq("single_err", bus.host_err_o, 3'b000);
    step();
    bus.dev_rvalid_i = 1'b0;

    // round-robin with all three hosts requesting
    reset_pulse();
    for (int h = 0; h < 3; h++) bus.host_addr_i[h] = rr_addr[h];
    bus.host_req_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      bus.dev_rvalid_i = (k > 0);
      bus.dev_rdata_i  = 32'h100 + k;
      @(negedge clk);
      check_eq($sformatf("rr_gnt%0d", k), bus.host_gnt_o, 3'b001 << order[k]);
      check_eq($sformatf("rr_addr%0d", k), bus.dev_addr_o, rr_addr[order[k]]);
      if (k > 0)
        check_eq($sformatf("rr_rvalid%0d", k), bus.host_rvalid_o, 3'b001 << order[k-1]);
      step();
      if (k >= 3) bus.host_req_i[order[k]] = 1'b0;
    end
    bus.dev_rvalid_i = 1'b1;
    @(negedge clk);
    check_eq("rr_drain_rvalid", bus.host_rvalid_o, 3'b100);
    check_eq("rr_drain_req", bus.dev_req_o, 1'b0);
    step();
    bus.dev_rvalid_i = 1'b0;

    // backpressure: two outstanding, then blocked until a response pops
    bus.host_addr_i[0] = 32'hB000_0000;
    bus.host_req_i[0]  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq($sformatf("bp_gnt%0d", c), bus.host_gnt_o, 3'b001);
      step();
    end
    for (int c = 2; c < 7; c++) begin
      @(negedge clk);
      check_eq($sformatf("bp_req_blocked%0d", c), bus.dev_req_o, 1'b0);
      check_eq($sformatf("bp_gnt_blocked%0d", c), bus.host_gnt_o, 3'b000);
      step();
    end
    bus.dev_rvalid_i = 1'b1;
    bus.dev_rdata_i  = 32'hA1;
    @(negedge clk);
    check_eq("bp_pop_rvalid", bus.host_rvalid_o, 3'b001);
    check_eq("bp_pop_no_req", bus.dev_req_o, 1'b0);
    step();
    bus.dev_rvalid_i = 1'b0;
    @(negedge clk);
    check_eq("bp_regrant", bus.host_gnt_o, 3'b001);
    step();
    bus.host_req_i[0] = 1'b0;
    bus.dev_rvalid_i  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq($sformatf("bp_drain%0d", c), bus.host_rvalid_o, 3'b001);
      step();
    end
    bus.dev_rvalid_i = 1'b0;

    // in-order routing: host1 then host0, error on the second response
    bus.host_addr_i[0] = 32'h0000_0A00;
    bus.host_addr_i[1] = 32'h0000_0B00;
    bus.host_req_i     = 3'b011;
    @(negedge clk);
    check_eq("ord_gnt_h1", bus.host_gnt_o, 3'b010);
    check_eq("ord_addr_h1", bus.dev_addr_o, 32'h0000_0B00);
    step();
    bus.host_req_i[1] = 1'b0;
    @(negedge clk);
    check_eq("ord_gnt_h0", bus.host_gnt_o, 3'b001);
    check_eq("ord_addr_h0", bus.dev_addr_o, 32'h0000_0A00);
    step();
    bus.host_req_i[0] = 1'b0;
    bus.dev_rvalid_i  = 1'b1;
    bus.dev_rdata_i   = 32'h11;
    bus.dev_err_i     = 1'b0;
    @(negedge clk);
    check_eq("ord_rvalid_h1", bus.host_rvalid_o, 3'b010);
    check_eq("ord_err_h1", bus.host_err_o, 3'b000);
    check_eq("ord_rdata_h1", bus.host_rdata_o[1], 32'h11);
    step();
    bus.dev_rdata_i = 32'h22;
    bus.dev_err_i   = 1'b1;
    @(negedge clk);
    check_eq("ord_rvalid_h0", bus.host_rvalid_o, 3'b001);
    check_eq("ord_err_h0", bus.host_err_o, 3'b001);
    check_eq("ord_rdata_h0", bus.host_rdata_o[0], 32'h22);
    step();
    bus.dev_rvalid_i = 1'b0;
    bus.dev_err_i    = 1'b0;

    // downstream stall: request held, pointer frozen until dev_gnt_i rises
    reset_pulse();
    bus.host_addr_i[0]  = 32'h0000_5000;
    bus.host_we_i[0]    = 1'b1;
    bus.host_be_i[0]    = 4'h3;
    bus.host_wdata_i[0] = 32'hCAFE_F00D;
    bus.host_req_i[0]   = 1'b1;
    bus.dev_gnt_i       = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_eq($sformatf("stall_req%0d", s), bus.dev_req_o, 1'b1);
      check_eq($sformatf("stall_gnt%0d", s), bus.host_gnt_o, 3'b000);
      check_eq($sformatf("stall_addr%0d", s), bus.dev_addr_o, 32'h0000_5000);
      check_eq($sformatf("stall_we%0d", s), bus.dev_we_o, 1'b1);
      check_eq($sformatf("stall_be%0d", s), bus.dev_be_o, 4'h3);
      check_eq($sformatf("stall_wdata%0d", s), bus.dev_wdata_o, 32'hCAFE_F00D);
      check_eq($sformatf("stall_ptr%0d", s), dut.r_rr_ptr, 2'd0);
      step();
    end
    bus.dev_gnt_i = 1'b1;
    @(negedge clk);
    check_eq("stall_release_gnt", bus.host_gnt_o, 3'b001);
    step();
    bus.host_req_i[0] = 1'b0;
    bus.dev_rvalid_i  = 1'b1;
    @(negedge clk);
    check_eq("stall_ptr_after", dut.r_rr_ptr, 2'd1);
    check_eq("stall_rvalid", bus.host_rvalid_o, 3'b001);
    step();
    bus.dev_rvalid_i = 1'b0;

    // spurious response, then reset mid-transaction
    bus.dev_rvalid_i = 1'b1;
    @(negedge clk);
    check_eq("spur_no_rvalid", bus.host_rvalid_o, 3'b000);
    check_eq("spur_not_yet", spurious, 1'b0);
    step();
    bus.dev_rvalid_i  = 1'b0;
    bus.host_req_i[0] = 1'b1;
    @(negedge clk);
    check_eq("spur_set", spurious, 1'b1);
    check_eq("spur_gnt", bus.host_gnt_o, 3'b001);
    step();
    bus.host_req_i[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_count", dut.r_count, 2'd0);
    check_eq("midrst_spur_clr", spurious, 1'b0);
    bus.host_req_i[0] = 1'b1;
    @(negedge clk);
    check_eq("midrst_dev_req", bus.dev_req_o, 1'b0);
    check_eq("midrst_gnt", bus.host_gnt_o, 3'b000);
    bus.host_req_i[0] = 1'b0;
    step();
    rst_n = 1'b1;
    bus.dev_rvalid_i = 1'b1;
    @(negedge clk);
    check_eq("post_rst_no_rvalid", bus.host_rvalid_o, 3'b000);
    step();
    bus.dev_rvalid_i = 1'b0;
    @(negedge clk);
    check_eq("post_rst_spur", spurious, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
